// File: rtl/clkgen_div_multi.sv
// Multi-channel integer clock divider with a post-reset lock delay, phase-aligned start
// and glitch-free runtime ratio updates through a valid/ready configuration port.
module clkgen_div_multi #(
  parameter int NumCh = 3,
  parameter int DivW = 8,
  parameter logic [NumCh*DivW-1:0] DefDiv = {8'd5, 8'd3, 8'd2},
  parameter int LockCycles = 64,
  localparam int ChW = (NumCh > 1) ? $clog2(NumCh) : 1
) (
  input  logic             board_clk_i,
  input  logic             RESETn_i,
  input  logic [NumCh-1:0] ch_en_i,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  input  logic [ChW-1:0]   cfg_ch_i,
  input  logic [DivW-1:0]  cfg_div_i,
  output logic             cfg_err_o,
  output logic [NumCh-1:0] clk_o,
  output logic [NumCh-1:0] clk_pulse_o,
  output logic             locked_o
);

  localparam int LockW = (LockCycles > 1) ? $clog2(LockCycles) : 1;
  localparam logic [LockW-1:0] LockLast = LockW'(LockCycles - 1);
  localparam logic [ChW:0] NumChW = (ChW + 1)'(NumCh);
  localparam logic [DivW-1:0] MinDiv = DivW'(2);

  typedef enum logic {LOCKING, LOCKED} lockState_t;
  typedef enum logic {STOP, RUN} chState_t;

  lockState_t       r_lockState, w_lockStateNext;
  logic [LockW-1:0] r_lockCnt, w_lockCntNext;
  logic             w_locked;

  chState_t         r_chState [NumCh];
  chState_t         w_chStateNext [NumCh];
  logic [DivW-1:0]  r_cnt [NumCh];
  logic [DivW-1:0]  w_cntNext [NumCh];
  logic [DivW-1:0]  r_div [NumCh];
  logic [DivW-1:0]  w_divNext [NumCh];
  logic [DivW:0]    w_half [NumCh];
  logic [NumCh-1:0] w_last;

  logic [NumCh-1:0] r_clk, w_clkNext;
  logic [NumCh-1:0] r_pulse, w_pulseNext;
  logic             r_pend, w_pendNext;
  logic [ChW-1:0]   r_pendCh, w_pendChNext;
  logic [DivW-1:0]  r_pendDiv, w_pendDivNext;
  logic             r_ready;
  logic             r_err, w_errNext;
  logic             w_xfer, w_cfgLegal;

  always_ff @(posedge board_clk_i or negedge RESETn_i) begin
    if (!RESETn_i) begin
      r_lockState <= LOCKING;
      r_lockCnt   <= '0;
    end else begin
      r_lockState <= w_lockStateNext;
      r_lockCnt   <= w_lockCntNext;
    end
  end

  always_comb begin
    w_lockStateNext = r_lockState;
    w_lockCntNext   = r_lockCnt;
    if (r_lockState == LOCKING) begin
      if (r_lockCnt == LockLast) w_lockStateNext = LOCKED;
      else w_lockCntNext = r_lockCnt + LockW'(1);
    end
  end

  assign w_locked = (r_lockState == LOCKED);

  // High phase is ceil(N/2); one extra bit keeps N = 2**DivW-1 from wrapping.
  for (genvar g = 0; g < NumCh; g++) begin : g_ch
    assign w_half[g] = ({1'b0, r_div[g]} + {{DivW{1'b0}}, 1'b1}) >> 1;
    assign w_last[g] = (r_cnt[g] == r_div[g] - DivW'(1));
  end

  assign w_xfer     = cfg_valid_i & r_ready;
  assign w_cfgLegal = (cfg_div_i >= MinDiv) && ({1'b0, cfg_ch_i} < NumChW);

  always_comb begin
    w_pendNext    = r_pend;
    w_pendChNext  = r_pendCh;
    w_pendDivNext = r_pendDiv;
    w_errNext     = 1'b0;
    w_clkNext     = '0;
    w_pulseNext   = '0;
    for (int c = 0; c < NumCh; c++) begin
      w_chStateNext[c] = r_chState[c];
      w_cntNext[c]     = r_cnt[c];
      w_divNext[c]     = r_div[c];
      case (r_chState[c])
        STOP: if (w_locked && ch_en_i[c]) w_chStateNext[c] = RUN;
        RUN: begin
          w_clkNext[c]   = ({1'b0, r_cnt[c]} < w_half[c]);
          w_pulseNext[c] = (r_cnt[c] == '0);
          // Ratio changes and stop requests only ever land on the last cycle of a period.
          if (w_last[c]) begin
            w_cntNext[c] = '0;
            if (!ch_en_i[c]) w_chStateNext[c] = STOP;
            if (r_pend && (r_pendCh == ChW'(c))) begin
              w_divNext[c] = r_pendDiv;
              w_pendNext   = 1'b0;
            end
          end else begin
            w_cntNext[c] = r_cnt[c] + DivW'(1);
          end
        end
        default: w_chStateNext[c] = STOP;
      endcase
    end
    if (w_xfer) begin
      if (!w_cfgLegal) begin
        w_errNext = 1'b1;
      end else begin
        for (int c = 0; c < NumCh; c++) begin
          if (cfg_ch_i == ChW'(c)) begin
            if (r_chState[c] == STOP) begin
              w_divNext[c] = cfg_div_i;
            end else begin
              w_pendNext    = 1'b1;
              w_pendChNext  = cfg_ch_i;
              w_pendDivNext = cfg_div_i;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge board_clk_i or negedge RESETn_i) begin
    if (!RESETn_i) begin
      for (int c = 0; c < NumCh; c++) begin
        r_chState[c] <= STOP;
        r_cnt[c]     <= '0;
        r_div[c]     <= DefDiv[c*DivW +: DivW];
      end
      r_clk     <= '0;
      r_pulse   <= '0;
      r_pend    <= 1'b0;
      r_pendCh  <= '0;
      r_pendDiv <= '0;
      r_ready   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      for (int c = 0; c < NumCh; c++) begin
        r_chState[c] <= w_chStateNext[c];
        r_cnt[c]     <= w_cntNext[c];
        r_div[c]     <= w_divNext[c];
      end
      r_clk     <= w_clkNext;
      r_pulse   <= w_pulseNext;
      r_pend    <= w_pendNext;
      r_pendCh  <= w_pendChNext;
      r_pendDiv <= w_pendDivNext;
      r_ready   <= !w_pendNext;
      r_err     <= w_errNext;
    end
  end

  assign clk_o       = r_clk;
  assign clk_pulse_o = r_pulse;
  assign cfg_ready_o = r_ready;
  assign cfg_err_o   = r_err;
  assign locked_o    = w_locked;

endmodule
